counter_rr_scheduler: RTL and testbench

//  Shares one 4-bit up-counter (count_en in, q_out out) between NUM_REQ requesters.

---
 rtl/counter_rr_scheduler.sv | 178 +++++++++++++++++
 tb/tb_counter_rr_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// counter_rr_scheduler
//   Round-robin scheduler sharing one up-counter among NUM_REQ requesters.
//   Each granted requester gets a burst of count_en cycles, then a done pulse.
//   Optional macro SCHED_COUNT_CHECK_EN adds a sticky check of the counter delta.
//   Revision: 1.0
// ============================================================================
module counter_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     count_en,
  input  logic [CNT_W-1:0]         q_out,
  output logic                     busy,
  output logic                     err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_rem;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_count_en;
  logic               r_busy;

  logic               w_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [CNT_W-1:0]   w_sel_len;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic [IDX_W-1:0]   w_idx_next;
  logic [CNT_W-1:0]   w_len_arr [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_len
      assign w_len_arr[g] = req_len[g*CNT_W +: CNT_W];
    end
  endgenerate

  // First pending request at or after the pointer, wrapping around.
  always_comb begin : p_arb
    int w_sum;
    logic [IDX_W-1:0] w_j;
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sel_len = '0;
    w_sum     = 0;
    w_j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_j = IDX_W'(w_sum);
      if (!w_found && req[w_j]) begin
        w_found   = 1'b1;
        w_sel_idx = w_j;
        w_sel_len = w_len_arr[w_j];
      end
    end
  end

  assign w_sel_onehot = NUM_REQ'(1) << w_sel_idx;
  assign w_idx_next   = (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_count_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt  <= w_sel_onehot;
            r_idx  <= w_sel_idx;
            r_rem  <= w_sel_len;
            r_busy <= 1'b1;
            if (w_sel_len != '0) begin
              r_state    <= S_RUN;
              r_count_en <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= w_sel_onehot;
            end
          end
        end
        S_RUN: begin
          // A dropped request abandons the burst without a done pulse.
          if (!req[r_idx]) begin
            r_state    <= S_IDLE;
            r_count_en <= 1'b0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= w_idx_next;
          end else if (r_rem == CNT_W'(1)) begin
            r_state    <= S_DONE;
            r_count_en <= 1'b0;
            r_done     <= r_gnt;
          end else begin
            r_rem <= r_rem - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_idx_next;
        end
        default: begin
          r_state    <= S_IDLE;
          r_gnt      <= '0;
          r_done     <= '0;
          r_count_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign count_en = r_count_en;
  assign busy     = r_busy;

`ifdef SCHED_COUNT_CHECK_EN
  logic [CNT_W-1:0] r_base;
  logic [CNT_W-1:0] r_len;
  logic             r_err;

  // Counter delta is taken modulo 2^CNT_W, so wrap-around mid-burst is benign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_base <= q_out;
        r_len  <= w_sel_len;
      end
      if (r_state == S_DONE && CNT_W'(q_out - r_base) != r_len) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_q;
  assign w_unused_q = ^q_out;
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_counter_rr_scheduler
//   Directed bench for counter_rr_scheduler with a behavioural 4-bit counter.
//   Revision: 1.0
// ============================================================================
module tb_counter_rr_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        count_en;
  logic [3:0]  q_out;
  logic        busy;
  logic        err;

  logic        load;
  logic [3:0]  load_val;
  logic        skip;

  int n_checks;
  int n_pass;

  counter_rr_scheduler #(
    .NUM_REQ (4),
    .CNT_W   (4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .count_en (count_en),
    .q_out    (q_out),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model; skip suppresses increments to emulate a faulty counter.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_out <= 4'd0;
    end else if (load) begin
      q_out <= load_val;
    end else if (count_en && !skip) begin
      q_out <= q_out + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input int idx, input int len, input bit drop);
    int waitc;
    int cnt;
    waitc = 0;
    while (gnt == 4'd0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("gnt_onehot", 32'(gnt), 32'(1 << idx));
    cnt   = 0;
    waitc = 0;
    while (done == 4'd0 && waitc < 40) begin
      if (count_en) cnt++;
      @(negedge clk);
      waitc++;
    end
    chk("en_cycles", 32'(cnt), 32'(len));
    chk("done_pulse", 32'(done), 32'(1 << idx));
    chk("gnt_in_done", 32'(gnt), 32'(1 << idx));
    chk("busy_in_done", 32'(busy), 32'd1);
    if (drop) req[idx] = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    req      = 4'd0;
    req_len  = 16'd0;
    load     = 1'b0;
    load_val = 4'd0;
    skip     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(count_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single request, length 5 from q_out = 0
    req_len[3:0] = 4'd5;
    req          = 4'b0001;
    run_burst(0, 5, 1'b1);
    chk("single_q", 32'(q_out), 32'd5);
    chk("single_err", 32'(err), 32'd0);

    // Round-robin with all requesters held, len 2 each
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    req_len = 16'h2222;
    req     = 4'b1111;
    run_burst(0, 2, 1'b0);
    run_burst(1, 2, 1'b0);
    run_burst(2, 2, 1'b0);
    run_burst(3, 2, 1'b0);
    run_burst(0, 2, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    chk("rr_idle_gnt", 32'(gnt), 32'd0);

    // Zero-length burst on requester 2
    req_len[11:8] = 4'd0;
    req           = 4'b0100;
    run_burst(2, 0, 1'b1);

    // Wrap: q_out 14 at grant, length 3
    load     = 1'b1;
    load_val = 4'd14;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_start", 32'(q_out), 32'd14);
    req_len[3:0] = 4'd3;
    req          = 4'b0001;
    run_burst(0, 3, 1'b1);
    chk("wrap_q", 32'(q_out), 32'd1);
    chk("wrap_err", 32'(err), 32'd0);

    // Abort requester 1 after 2 of 6 cycles; requester 2 pending
    req_len[7:4]  = 4'd6;
    req_len[11:8] = 4'd1;
    req           = 4'b0110;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'b0010);
    chk("abort_en1", 32'(count_en), 32'd1);
    @(negedge clk);
    chk("abort_en2", 32'(count_en), 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    chk("abort_en_off", 32'(count_en), 32'd0);
    chk("abort_gnt_off", 32'(gnt), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    run_burst(2, 1, 1'b1);

    // Asynchronous reset in the middle of a burst
    req_len[3:0] = 4'd6;
    req          = 4'b0001;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", 32'(count_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_en", 32'(count_en), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    reset        = 1'b0;
    req_len      = 16'h1002;
    req          = 4'b1001;
    run_burst(0, 2, 1'b1);
    run_burst(3, 1, 1'b1);
    chk("final_err", 32'(err), 32'd0);

`ifdef SCHED_COUNT_CHECK_EN
    // Counter that never advances must trip the sticky error after DONE
    skip         = 1'b1;
    req_len[7:4] = 4'd3;
    req          = 4'b0010;
    run_burst(1, 3, 1'b1);
    skip = 1'b0;
    chk("skip_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("skip_err_sticky", 32'(err), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
